// File: rtl/gcd_seq.sv
// Sequential GCD engine: one reduction step per clock, subtractive Euclid (MODE 0)
// or binary Stein (MODE 1), with a one-cycle Done pulse and an iteration count.
module gcd_seq #(
  parameter int WIDTH = 8,
  parameter int MODE  = 0,
  parameter int CNT_W = WIDTH + 1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] gcd_output,
  output logic [CNT_W-1:0] Cycles,
  output logic             state_dbg
);

  localparam int K_W = $clog2(WIDTH) + 1;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [K_W-1:0]   k;
  logic [CNT_W-1:0] cnt;

  assign state_dbg = (state == RUN);

  // Handshake: a request is taken on any edge where Start=1 and the engine is in
  // IDLE (Busy=0); requests while Busy=1 are dropped, not queued. Done marks the
  // first IDLE cycle, so a Start held through it is accepted with no gap.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state      <= IDLE;
      a          <= '0;
      b          <= '0;
      k          <= '0;
      cnt        <= '0;
      Busy       <= 1'b0;
      Done       <= 1'b0;
      gcd_output <= '0;
      Cycles     <= '0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (Start) begin
            a     <= X;
            b     <= Y;
            k     <= '0;
            cnt   <= '0;
            Busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          cnt <= cnt + CNT_W'(1);
          if (a == '0 || b == '0) begin
            // Zero operand yields 0, matching the legacy combinational datapath.
            gcd_output <= '0;
            Cycles     <= cnt + CNT_W'(1);
            Done       <= 1'b1;
            Busy       <= 1'b0;
            state      <= IDLE;
          end else if (a == b) begin
            gcd_output <= a << k;
            Cycles     <= cnt + CNT_W'(1);
            Done       <= 1'b1;
            Busy       <= 1'b0;
            state      <= IDLE;
          end else if (MODE == 0) begin
            if (a > b) a <= a - b;
            else       b <= b - a;
          end else begin
            if (!a[0] && !b[0]) begin
              a <= a >> 1;
              b <= b >> 1;
              k <= k + K_W'(1);
            end else if (!a[0]) begin
              a <= a >> 1;
            end else if (!b[0]) begin
              b <= b >> 1;
            end else if (a > b) begin
              a <= a - b;
            end else begin
              b <= b - a;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_seq.sv
// Bench for gcd_seq: one MODE 0 and one MODE 1 instance sharing operands and reset,
// directed cases from the plan plus random pairs against an arithmetic reference.
module tb_gcd_seq;

  localparam int W  = 8;
  localparam int CW = W + 1;

  logic          clk;
  logic          rst;
  logic          start0, start1;
  logic [W-1:0]  x, y;
  logic          busy0, busy1, done0, done1, dbg0, dbg1;
  logic [W-1:0]  gcd0, gcd1;
  logic [CW-1:0] cyc0, cyc1;

  logic [W-1:0]  exp_q[$];
  logic [CW-1:0] cyc_q[$];
  int n_cmp = 0;
  int n_err = 0;

  gcd_seq #(.WIDTH(W), .MODE(0), .CNT_W(CW)) u_sub (
    .Clk(clk), .Reset(rst), .Start(start0), .X(x), .Y(y),
    .Busy(busy0), .Done(done0), .gcd_output(gcd0), .Cycles(cyc0), .state_dbg(dbg0)
  );

  gcd_seq #(.WIDTH(W), .MODE(1), .CNT_W(CW)) u_bin (
    .Clk(clk), .Reset(rst), .Start(start1), .X(x), .Y(y),
    .Busy(busy1), .Done(done1), .gcd_output(gcd1), .Cycles(cyc1), .state_dbg(dbg1)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model
  function automatic int gcd_ref(input int p, input int q);
    int t;
    if (p == 0 || q == 0) return 0;
    while (q != 0) begin
      t = p % q;
      p = q;
      q = t;
    end
    return p;
  endfunction

  // Subtractive Euclid performs (quotient sum - 1) subtractions; N = that + 1.
  function automatic int sub_cycles(input int p, input int q);
    int n, t;
    if (p == 0 || q == 0) return 1;
    n = 0;
    while (q != 0) begin
      n += p / q;
      t = p % q;
      p = q;
      q = t;
    end
    return n;
  endfunction

  function automatic int stein_cycles(input int p, input int q);
    int n;
    if (p == 0 || q == 0) return 1;
    n = 1;
    while (p != q) begin
      n++;
      if (p % 2 == 0 && q % 2 == 0) begin p /= 2; q /= 2; end
      else if (p % 2 == 0) p /= 2;
      else if (q % 2 == 0) q /= 2;
      else if (p > q) p -= q;
      else q -= p;
    end
    return n;
  endfunction

  // checking
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic busy_of(input int m);
    return (m != 0) ? busy1 : busy0;
  endfunction
  function automatic logic done_of(input int m);
    return (m != 0) ? done1 : done0;
  endfunction
  function automatic logic [W-1:0] gcd_of(input int m);
    return (m != 0) ? gcd1 : gcd0;
  endfunction
  function automatic logic [CW-1:0] cyc_of(input int m);
    return (m != 0) ? cyc1 : cyc0;
  endfunction

  task automatic set_start(input int m, input logic v);
    if (m != 0) start1 = v;
    else        start0 = v;
  endtask

  // Wait from the negedge after the accept edge until Done; returns edges counted.
  task automatic wait_done(input int m, input int poke_at, output int edges);
    edges = 0;
    do begin
      if (edges == poke_at) begin
        x = 8'd12; y = 8'd6;
        set_start(m, 1'b1);
      end else begin
        set_start(m, 1'b0);
      end
      @(negedge clk);
      edges++;
    end while (!done_of(m) && edges < 400);
    set_start(m, 1'b0);
    check("done_seen", done_of(m), 1);
  endtask

  task automatic run_op(input int m, input int px, input int py, input int poke_at);
    int edges;
    logic [W-1:0]  eg;
    logic [CW-1:0] ec;
    exp_q.push_back(W'(gcd_ref(px, py)));
    cyc_q.push_back(CW'((m != 0) ? stein_cycles(px, py) : sub_cycles(px, py)));
    @(negedge clk);
    x = W'(px); y = W'(py);
    set_start(m, 1'b1);
    @(negedge clk);
    set_start(m, 1'b0);
    x = W'($urandom_range(0, 255)); y = W'($urandom_range(0, 255));
    check("busy_after_accept", busy_of(m), 1);
    wait_done(m, poke_at, edges);
    eg = exp_q.pop_front();
    ec = cyc_q.pop_front();
    check("gcd_output", gcd_of(m), eg);
    check("cycles", cyc_of(m), ec);
    check("latency", edges, ec);
    check("busy_low_at_done", busy_of(m), 0);
    @(negedge clk);
    check("done_single_pulse", done_of(m), 0);
    check("gcd_held", gcd_of(m), eg);
  endtask

  // stimulus
  initial begin
    int edges;
    int m;
    int seen;
    rst = 1'b1; start0 = 1'b0; start1 = 1'b0; x = '0; y = '0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("rst_busy", busy_of(i), 0);
      check("rst_done", done_of(i), 0);
      check("rst_gcd", gcd_of(i), 0);
      check("rst_cycles", cyc_of(i), 0);
    end
    rst = 1'b0;

    // directed cases
    run_op(0, 6, 3, -1);
    check("m0_6_3_gcd", gcd0, 3);
    check("m0_6_3_cyc", cyc0, 2);
    run_op(0, 28, 28, -1);
    check("m0_28_28_cyc", cyc0, 1);
    run_op(1, 208, 64, -1);
    check("m1_208_64_gcd", gcd1, 16);
    check("m1_208_64_cyc", cyc1, 12);
    run_op(1, 158, 192, -1);
    check("m1_158_192_gcd", gcd1, 2);
    run_op(1, 38, 158, -1);
    check("m1_38_158_gcd", gcd1, 2);
    for (int md = 0; md < 2; md++) begin
      run_op(md, 0, 192, -1);
      run_op(md, 192, 0, -1);
      run_op(md, 0, 0, -1);
    end
    // worst case with a Start poked mid-run, which must be ignored
    run_op(0, 255, 1, 20);
    check("m0_255_1_cyc", cyc0, 255);
    check("m0_255_1_gcd", gcd0, 1);

    // back-to-back: Start held through the Done cycle
    @(negedge clk);
    x = 8'd12; y = 8'd3; start0 = 1'b1;
    @(negedge clk);
    edges = 0;
    while (!done0 && edges < 400) begin @(negedge clk); edges++; end
    check("b2b_first_gcd", gcd0, 3);
    check("b2b_first_done", done0, 1);
    x = 8'd1; y = 8'd2;
    @(negedge clk);
    start0 = 1'b0;
    check("b2b_no_bubble", busy0, 1);
    wait_done(0, -1, edges);
    check("b2b_second_gcd", gcd0, 1);
    check("b2b_second_lat", edges, 2);

    // reset in the middle of a long run
    @(negedge clk);
    x = 8'd255; y = 8'd1; start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    repeat (49) @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", busy0, 0);
    check("mid_rst_done", done0, 0);
    check("mid_rst_gcd", gcd0, 0);
    check("mid_rst_cycles", cyc0, 0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (300) begin
      @(negedge clk);
      if (done0 || busy0) seen++;
    end
    check("no_done_after_rst", seen, 0);
    run_op(0, 12, 6, -1);
    check("post_rst_gcd", gcd0, 6);

    // random pairs, random engine
    for (int i = 0; i < 40; i++) begin
      m = $urandom_range(0, 1);
      run_op(m, $urandom_range(0, 255), $urandom_range(0, 255), -1);
    end
    check("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
